ddr3_cmd_issue_phy: RTL and testbench

- Parametrised successor to the initialization-only command PHY.
- Accepts encoded controller commands through a valid/ready FIFO and drives the full DDR3 command/address pin set. Covers init, bank, refresh and power-down commands, multiple ranks, per-rank ODT timing and illegal-command detection.
- Sits between the command scheduler/init FSM and the DRAM pins. The data path is out of scope.

---
 rtl/ddr3_cmd_issue_phy.sv | 235 +++++++++++++++++++++++
 tb/tb_ddr3_cmd_issue_phy.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_cmd_issue_phy.sv
// rtl/ddr3_cmd_issue_phy.sv - queued DDR3 command/address pin driver with power state, ODT and illegal-command drop
module ddr3_cmd_issue_phy #(
  parameter int          BA_BITS    = 3,
  parameter int          ADDR_BITS  = 14,
  parameter int          RANKS      = 1,
  parameter int          FIFO_DEPTH = 4,
  parameter int          ODT_CYCLES = 6,
  parameter logic [15:0] MR0_VAL    = 16'h0000,
  parameter logic [15:0] MR1_VAL    = 16'h0000,
  parameter logic [15:0] MR2_VAL    = 16'h0000,
  parameter logic [15:0] MR3_VAL    = 16'h0000,
  localparam int         RANK_W     = (RANKS > 1) ? $clog2(RANKS) : 1,
  localparam int         LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk1,
  input  logic                 rst_n,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [3:0]           i_cmd,
  input  logic [RANK_W-1:0]    i_rank,
  input  logic [BA_BITS-1:0]   i_ba,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [1:0]           i_mr_num,
  input  logic                 i_auto_pre,
  output logic                 cke,
  output logic [RANKS-1:0]     cs_n,
  output logic                 ras_n,
  output logic                 cas_n,
  output logic                 we_n,
  output logic [BA_BITS-1:0]   ba,
  output logic [ADDR_BITS-1:0] addr,
  output logic [RANKS-1:0]     odt,
  output logic                 o_issue,
  output logic                 o_err,
  output logic [LVL_W-1:0]     o_fifo_level
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(ODT_CYCLES + 1);
  localparam int ENT_W = 4 + RANK_W + BA_BITS + ADDR_BITS + 2 + 1;

  localparam logic [3:0] C_NOP      = 4'd0;
  localparam logic [3:0] C_MRS      = 4'd1;
  localparam logic [3:0] C_ZQCL     = 4'd2;
  localparam logic [3:0] C_ACT      = 4'd3;
  localparam logic [3:0] C_RD       = 4'd4;
  localparam logic [3:0] C_WR       = 4'd5;
  localparam logic [3:0] C_PRE      = 4'd6;
  localparam logic [3:0] C_PREA     = 4'd7;
  localparam logic [3:0] C_REF      = 4'd8;
  localparam logic [3:0] C_CKE_LOW  = 4'd9;
  localparam logic [3:0] C_CKE_HIGH = 4'd10;

  typedef enum logic {PS_PD, PS_ACTIVE} pwr_t;
  pwr_t state_q, state_d;

  logic [ENT_W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 ready_q;
  logic                 push, pop;

  logic [3:0]           h_cmd;
  logic [RANK_W-1:0]    h_rank;
  logic [BA_BITS-1:0]   h_ba;
  logic [ADDR_BITS-1:0] h_addr;
  logic [1:0]           h_mr;
  logic                 h_ap;
  logic [15:0]          mr_sel;
  logic [RANKS-1:0]     rank_oh;

  logic [RANKS-1:0]     cs_n_q, cs_n_d;
  logic [2:0]           rcw_q, rcw_d;
  logic [BA_BITS-1:0]   ba_q, ba_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 issue_q, issue_d, err_q, err_d;
  logic [RANKS-1:0]     odt_load;
  logic                 odt_clear;
  logic [CNT_W-1:0]     odt_cnt [RANKS];

  // Ready comes only from registered state, so the upstream never sees a pop-to-ready path.
  assign push = i_cmd_valid && ready_q;
  assign pop  = (level_q != '0);

  assign {h_cmd, h_rank, h_ba, h_addr, h_mr, h_ap} = mem[rd_ptr];
  assign rank_oh = RANKS'(1) << h_rank;

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;
  end

  always_comb begin
    case (h_mr)
      2'd0:    mr_sel = MR0_VAL;
      2'd1:    mr_sel = MR1_VAL;
      2'd2:    mr_sel = MR2_VAL;
      default: mr_sel = MR3_VAL;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (push) mem[wr_ptr] <= {i_cmd, i_rank, i_ba, i_addr, i_mr_num, i_auto_pre};
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level_q <= level_d;
      ready_q <= (level_d != LVL_W'(FIFO_DEPTH));
    end
  end

  // Decode of the popped head; anything not issued leaves the bus deselected with ba/addr held.
  always_comb begin
    state_d   = state_q;
    cs_n_d    = '1;
    rcw_d     = 3'b111;
    ba_d      = ba_q;
    addr_d    = addr_q;
    issue_d   = 1'b0;
    err_d     = 1'b0;
    odt_load  = '0;
    odt_clear = 1'b0;
    if (pop) begin
      case (h_cmd)
        C_NOP: ;
        C_CKE_HIGH: begin
          if (state_q == PS_PD) state_d = PS_ACTIVE;
        end
        C_CKE_LOW: begin
          if (state_q == PS_ACTIVE) begin
            state_d   = PS_PD;
            odt_clear = 1'b1;
          end
        end
        C_MRS, C_ZQCL, C_ACT, C_RD, C_WR, C_PRE, C_PREA, C_REF: begin
          if (state_q == PS_PD) begin
            err_d = 1'b1;
          end else begin
            issue_d = 1'b1;
            cs_n_d  = ~rank_oh;
            case (h_cmd)
              C_MRS: begin
                cs_n_d = '0;
                rcw_d  = 3'b000;
                ba_d   = BA_BITS'(h_mr);
                addr_d = ADDR_BITS'(mr_sel);
              end
              C_ZQCL: begin
                cs_n_d     = '0;
                rcw_d      = 3'b110;
                ba_d       = '0;
                addr_d     = '0;
                addr_d[10] = 1'b1;
              end
              C_ACT: begin
                rcw_d  = 3'b011;
                ba_d   = h_ba;
                addr_d = h_addr;
              end
              C_RD, C_WR: begin
                rcw_d      = (h_cmd == C_RD) ? 3'b101 : 3'b100;
                ba_d       = h_ba;
                addr_d     = h_addr;
                addr_d[10] = h_ap;
                addr_d[12] = 1'b1;
                if (h_cmd == C_WR) odt_load = rank_oh;
              end
              C_PRE: begin
                rcw_d      = 3'b010;
                ba_d       = h_ba;
                addr_d[10] = 1'b0;
              end
              C_PREA: begin
                rcw_d      = 3'b010;
                addr_d[10] = 1'b1;
              end
              default: rcw_d = 3'b001;
            endcase
          end
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PS_PD;
      cs_n_q  <= '1;
      rcw_q   <= 3'b111;
      ba_q    <= '0;
      addr_q  <= '0;
      issue_q <= 1'b0;
      err_q   <= 1'b0;
      for (int r = 0; r < RANKS; r++) odt_cnt[r] <= '0;
    end else begin
      state_q <= state_d;
      cs_n_q  <= cs_n_d;
      rcw_q   <= rcw_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      issue_q <= issue_d;
      err_q   <= err_d;
      for (int r = 0; r < RANKS; r++) begin
        if (odt_clear)                odt_cnt[r] <= '0;
        else if (odt_load[r])         odt_cnt[r] <= CNT_W'(ODT_CYCLES);
        else if (odt_cnt[r] != '0)    odt_cnt[r] <= odt_cnt[r] - 1'b1;
      end
    end
  end

  for (genvar r = 0; r < RANKS; r++) begin : g_odt
    assign odt[r] = (odt_cnt[r] != '0);
  end

  assign cke                  = (state_q == PS_ACTIVE);
  assign cs_n                 = cs_n_q;
  assign {ras_n, cas_n, we_n} = rcw_q;
  assign ba                   = ba_q;
  assign addr                 = addr_q;
  assign o_issue              = issue_q;
  assign o_err                = err_q;
  assign o_cmd_ready          = ready_q;
  assign o_fifo_level         = level_q;

endmodule

// File: tb/tb_ddr3_cmd_issue_phy.sv
// tb/tb_ddr3_cmd_issue_phy.sv - scoreboard bench for ddr3_cmd_issue_phy with a rule-level pin model
module tb_ddr3_cmd_issue_phy;
  localparam int BA_BITS = 3, ADDR_BITS = 14, RANKS = 2, FIFO_DEPTH = 4, ODT_CYCLES = 6;
  localparam int RANK_W = 1, LVL_W = 3;
  localparam logic [15:0] MR0 = 16'h1B30, MR1 = 16'h0044, MR2 = 16'h0208, MR3 = 16'h0018;

  logic clk1 = 1'b0, rst_n = 1'b0;
  logic i_cmd_valid, o_cmd_ready, i_auto_pre, cke, ras_n, cas_n, we_n, o_issue, o_err;
  logic [3:0] i_cmd;
  logic [RANK_W-1:0] i_rank;
  logic [BA_BITS-1:0] i_ba, ba;
  logic [ADDR_BITS-1:0] i_addr, addr;
  logic [1:0] i_mr_num;
  logic [RANKS-1:0] cs_n, odt;
  logic [LVL_W-1:0] o_fifo_level;

  ddr3_cmd_issue_phy #(
    .BA_BITS(BA_BITS), .ADDR_BITS(ADDR_BITS), .RANKS(RANKS), .FIFO_DEPTH(FIFO_DEPTH),
    .ODT_CYCLES(ODT_CYCLES), .MR0_VAL(MR0), .MR1_VAL(MR1), .MR2_VAL(MR2), .MR3_VAL(MR3)
  ) dut (
    .clk1(clk1), .rst_n(rst_n), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd(i_cmd), .i_rank(i_rank), .i_ba(i_ba), .i_addr(i_addr), .i_mr_num(i_mr_num),
    .i_auto_pre(i_auto_pre), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .addr(addr), .odt(odt), .o_issue(o_issue), .o_err(o_err), .o_fifo_level(o_fifo_level)
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    logic                 issue;
    logic                 err;
    logic                 cke;
    logic [RANKS-1:0]     cs_n;
    logic [2:0]           rcw;
    logic [BA_BITS-1:0]   ba;
    logic [ADDR_BITS-1:0] addr;
    int                   wr_rank;
    bit                   odt_clr;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_bad = 0, push_count = 0;

  bit                   s_active;
  logic [BA_BITS-1:0]   s_ba;
  logic [ADDR_BITS-1:0] s_addr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req);
    end
  endtask

  // Pin outcome of one command, applied in queue order to the modelled power state and held bus.
  function automatic exp_t model_cmd(input logic [3:0] c, input logic [RANK_W-1:0] rk,
                                     input logic [BA_BITS-1:0] b, input logic [ADDR_BITS-1:0] a,
                                     input logic [1:0] mr, input logic ap);
    exp_t e;
    logic [15:0] mv;
    e.issue = 0; e.err = 0; e.cs_n = '1; e.rcw = 3'b111; e.wr_rank = -1; e.odt_clr = 0;
    if (c == 4'd10) s_active = 1;
    else if (c == 4'd9) begin
      if (s_active) e.odt_clr = 1;
      s_active = 0;
    end else if (c >= 4'd1 && c <= 4'd8) begin
      if (!s_active) e.err = 1;
      else begin
        e.issue = 1;
        e.cs_n = (rk == 0) ? 2'b10 : 2'b01;
        case (c)
          4'd1: begin
            mv = (mr == 0) ? MR0 : (mr == 1) ? MR1 : (mr == 2) ? MR2 : MR3;
            e.cs_n = 2'b00; e.rcw = 3'b000; s_ba = {1'b0, mr}; s_addr = mv[ADDR_BITS-1:0];
          end
          4'd2: begin e.cs_n = 2'b00; e.rcw = 3'b110; s_ba = 0; s_addr = 14'h0400; end
          4'd3: begin e.rcw = 3'b011; s_ba = b; s_addr = a; end
          4'd4, 4'd5: begin
            e.rcw = (c == 4'd4) ? 3'b101 : 3'b100;
            s_ba = b; s_addr = a; s_addr[10] = ap; s_addr[12] = 1'b1;
            if (c == 4'd5) e.wr_rank = int'(rk);
          end
          4'd6: begin e.rcw = 3'b010; s_ba = b; s_addr[10] = 1'b0; end
          4'd7: begin e.rcw = 3'b010; s_addr[10] = 1'b1; end
          default: e.rcw = 3'b001;
        endcase
      end
    end else if (c != 4'd0) e.err = 1;
    e.cke = s_active; e.ba = s_ba; e.addr = s_addr;
    return e;
  endfunction

  task automatic send(input logic [3:0] c, input logic [RANK_W-1:0] rk, input logic [BA_BITS-1:0] b,
                      input logic [ADDR_BITS-1:0] a, input logic [1:0] mr, input logic ap);
    int t = 0;
    @(negedge clk1);
    i_cmd_valid = 1; i_cmd = c; i_rank = rk; i_ba = b; i_addr = a; i_mr_num = mr; i_auto_pre = ap;
    while (!o_cmd_ready && t < 100) begin
      @(negedge clk1);
      t++;
    end
    if (!o_cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout t=%0t actual=0 required=1", $time);
    end else begin
      q.push_back(model_cmd(c, rk, b, a, mr, ap));
      push_count++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk1);
      i_cmd_valid = 0;
    end
  endtask

  // Monitor: a pin cycle follows every edge at which the modelled FIFO held something.
  initial begin : monitor
    int cyc = 0, seen = 0, m_level = 0;
    int odt_end [RANKS];
    bit popped, pushed;
    logic m_cke;
    logic [BA_BITS-1:0] m_ba;
    logic [ADDR_BITS-1:0] m_addr;
    logic [RANKS-1:0] exp_odt;
    exp_t e;
    m_cke = 0; m_ba = 0; m_addr = 0;
    for (int r = 0; r < RANKS; r++) odt_end[r] = 0;
    forever begin
      @(posedge clk1);
      #1;
      cyc++;
      if (!rst_n) begin
        q.delete(); m_level = 0; seen = push_count; m_cke = 0; m_ba = 0; m_addr = 0;
        for (int r = 0; r < RANKS; r++) odt_end[r] = 0;
        chk("reset_pins", {o_issue, o_err, cke, cs_n, ras_n, cas_n, we_n, ba, addr, odt},
            {3'b000, 2'b11, 3'b111, 3'd0, 14'd0, 2'b00});
        chk("reset_lvl_rdy", {o_fifo_level, o_cmd_ready}, {3'd0, 1'b0});
      end else begin
        popped = (m_level > 0);
        pushed = (push_count != seen);
        seen = push_count;
        m_level = m_level + int'(pushed) - int'(popped);
        if (popped && q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_underflow t=%0t actual=pop required=empty", $time);
          popped = 0;
        end
        if (popped) begin
          e = q.pop_front();
          m_cke = e.cke; m_ba = e.ba; m_addr = e.addr;
          if (e.odt_clr) for (int r = 0; r < RANKS; r++) odt_end[r] = cyc;
          if (e.wr_rank >= 0) odt_end[e.wr_rank] = cyc + ODT_CYCLES;
        end else begin
          e.issue = 0; e.err = 0; e.cs_n = '1; e.rcw = 3'b111;
        end
        chk("pins", {o_issue, o_err, cke, cs_n, ras_n, cas_n, we_n, ba, addr},
            {e.issue, e.err, m_cke, e.cs_n, e.rcw, m_ba, m_addr});
        for (int r = 0; r < RANKS; r++) exp_odt[r] = (cyc < odt_end[r]);
        chk("odt", odt, exp_odt);
        chk("level", o_fifo_level, m_level);
        chk("ready", o_cmd_ready, (m_level != FIFO_DEPTH));
      end
    end
  end

  initial begin : stimulus
    logic [3:0] c;
    int pick;
    i_cmd_valid = 0; i_cmd = 0; i_rank = 0; i_ba = 0; i_addr = 0; i_mr_num = 0; i_auto_pre = 0;
    s_active = 0; s_ba = 0; s_addr = 0;
    rst_n = 0;
    repeat (3) @(negedge clk1);
    rst_n = 1;
    // power-up, MRS to MR2
    send(4'd10, 0, 0, 0, 0, 0);
    send(4'd1, 0, 0, 0, 2'd2, 0);
    idle(3);
    // ACT then WR with auto-precharge on rank 1
    send(4'd3, 1, 3'd3, 14'h1ABC, 0, 0);
    send(4'd5, 1, 3'd3, 14'h0040, 0, 1);
    idle(10);
    // two WRs to rank 0 three cycles apart
    send(4'd5, 0, 3'd1, 14'h0100, 0, 0);
    idle(2);
    send(4'd5, 0, 3'd1, 14'h0108, 0, 0);
    idle(12);
    // back-to-back ACTs
    for (int i = 0; i < 5; i++) send(4'd3, 1'(i), 3'(i), 14'(16'h0A00 + i), 0, 0);
    idle(4);
    // drop to PD, then REF and an undefined opcode are both rejected
    send(4'd9, 0, 0, 0, 0, 0);
    send(4'd8, 0, 0, 0, 0, 0);
    send(4'hF, 0, 0, 0, 0, 0);
    idle(5);
    // reset while ODT is active and commands are in flight
    send(4'd10, 0, 0, 0, 0, 0);
    send(4'd5, 0, 3'd2, 14'h0010, 0, 0);
    send(4'd3, 0, 3'd2, 14'h0222, 0, 0);
    send(4'd3, 1, 3'd4, 14'h0333, 0, 0);
    send(4'd3, 0, 3'd5, 14'h0444, 0, 0);
    @(negedge clk1);
    i_cmd_valid = 0;
    rst_n = 0;
    s_active = 0; s_ba = 0; s_addr = 0;
    #1;
    chk("async_reset", {cke, cs_n, odt, o_fifo_level, o_cmd_ready}, {1'b0, 2'b11, 2'b00, 3'd0, 1'b0});
    repeat (2) @(negedge clk1);
    rst_n = 1;
    idle(4);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 99);
      if (pick < 10)      c = 4'd10;
      else if (pick < 15) c = 4'd9;
      else if (pick < 20) c = 4'(11 + $urandom_range(0, 4));
      else if (pick < 25) c = 4'd0;
      else                c = 4'($urandom_range(1, 8));
      send(c, 1'($urandom), 3'($urandom), 14'($urandom), 2'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(20);
    chk("sb_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
